// File: rtl/wb_axi_fir_bridge_pkg.sv
// Shared definitions for the Wishbone-to-FIR bridge.
//   st_t      : bridge FSM state encoding
//   OFF_*     : Wishbone byte offsets (low address byte) with special meaning
package fir_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LWR   = 3'd1,
    ST_LRD_A = 3'd2,
    ST_LRD_D = 3'd3,
    ST_SSW   = 3'd4,
    ST_SMR   = 3'd5,
    ST_ACK   = 3'd6
  } st_t;

  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_LEN  = 8'h10;
  localparam logic [7:0] OFF_X    = 8'h80;
  localparam logic [7:0] OFF_Y    = 8'h84;

endpackage

// File: rtl/wb_axi_fir_bridge_if.sv
// Bus bundles around the FIR bridge.
//   fir_wb_if  : Wishbone classic slave port (management core is master)
//     master : cyc/stb/we/sel/adr/dat_i out, ack/dat_o in
//     slave  : the reverse
//   fir_axi_if : AXI-Lite config/tap port plus X (ss) and Y (sm) streams
//     master : bridge side (drives valids on AW/W/AR/ss, readies on R/sm)
//     slave  : FIR engine side
interface fir_wb_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

interface fir_axi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic              ss_tvalid, ss_tready, ss_tlast;
  logic [DATA_W-1:0] ss_tdata;
  logic              sm_tvalid, sm_tready;
  logic [DATA_W-1:0] sm_tdata;

  modport master (output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
                         ss_tvalid, ss_tdata, ss_tlast, sm_tready,
                  input  awready, wready, arready, rvalid, rdata, ss_tready,
                         sm_tvalid, sm_tdata);
  modport slave  (input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
                         ss_tvalid, ss_tdata, ss_tlast, sm_tready,
                  output awready, wready, arready, rvalid, rdata, ss_tready,
                         sm_tvalid, sm_tdata);
endinterface

// File: rtl/wb_axi_fir_bridge.sv
// Wishbone slave front end of the FIR engine. Turns firmware loads/stores into
// AXI-Lite accesses (offset < 0x80), X stream pushes (write 0x80) and Y stream
// pops (read 0x84); anything else inside the window acks with zero data.
// ss_tlast is generated here from the snooped data length register.
// Ports:
//   wb_clk_i  clock, rising edge
//   wb_rst_i  synchronous reset, active high
//   wb        Wishbone slave bundle
//   axi       AXI-Lite + AXI-Stream master bundle towards the FIR
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for a Wishbone request
// LWR      | AW and W offered; each drops on its own ready
// LRD_A    | AR offered until arready
// LRD_D    | rready held; rdata captured on rvalid
// SSW      | X sample offered until ss_tready
// SMR      | sm_tready held; Y sample captured on sm_tvalid
// ACK      | one-cycle Wishbone acknowledge with captured data
module wb_axi_fir_bridge
  import fir_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 12
) (
  input logic       wb_clk_i,
  input logic       wb_rst_i,
  fir_wb_if.slave   wb,
  fir_axi_if.master axi
);

  st_t               state_q, state_d;
  logic              aw_done_q, w_done_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] len_q;
  logic [DATA_W-1:0] x_cnt;
  logic              hit, req;
  logic [7:0]        off;
  logic              lite_done;
  logic              unused_bits;

  assign hit = (wb.wbs_adr_i[31:24] == BASE_ADDR[31:24]);
  assign req = wb.wbs_cyc_i & wb.wbs_stb_i & hit;
  assign off = wb.wbs_adr_i[7:0];

  // byte selects and the address bits between the Lite window and the decode byte are don't-care
  assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[23:ADDR_W]};

  // Wishbone holds address/data stable for the whole access, so these pass straight through
  assign axi.awaddr   = wb.wbs_adr_i[ADDR_W-1:0];
  assign axi.araddr   = wb.wbs_adr_i[ADDR_W-1:0];
  assign axi.wdata    = wb.wbs_dat_i;
  assign axi.ss_tdata = wb.wbs_dat_i;
  assign axi.ss_tlast = (len_q != '0) && (x_cnt == len_q - DATA_W'(1));

  // both channels done, counting a handshake happening this very cycle
  assign lite_done = (aw_done_q | axi.awready) & (w_done_q | axi.wready);

  always_comb begin
    state_d       = state_q;
    axi.awvalid   = 1'b0;
    axi.wvalid    = 1'b0;
    axi.arvalid   = 1'b0;
    axi.rready    = 1'b0;
    axi.ss_tvalid = 1'b0;
    axi.sm_tready = 1'b0;
    wb.wbs_ack_o  = 1'b0;
    wb.wbs_dat_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (off < OFF_X)                       state_d = wb.wbs_we_i ? ST_LWR : ST_LRD_A;
          else if (off == OFF_X && wb.wbs_we_i)  state_d = ST_SSW;
          else if (off == OFF_Y && !wb.wbs_we_i) state_d = ST_SMR;
          else                                   state_d = ST_ACK;
        end
      end
      ST_LWR: begin
        axi.awvalid = ~aw_done_q;
        axi.wvalid  = ~w_done_q;
        if (lite_done) state_d = ST_ACK;
      end
      ST_LRD_A: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = ST_LRD_D;
      end
      ST_LRD_D: begin
        axi.rready = 1'b1;
        if (axi.rvalid) state_d = ST_ACK;
      end
      ST_SSW: begin
        axi.ss_tvalid = 1'b1;
        if (axi.ss_tready) state_d = ST_ACK;
      end
      ST_SMR: begin
        axi.sm_tready = 1'b1;
        if (axi.sm_tvalid) state_d = ST_ACK;
      end
      ST_ACK: begin
        wb.wbs_ack_o = 1'b1;
        wb.wbs_dat_o = data_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_q    <= '0;
      len_q     <= '0;
      x_cnt     <= '0;
    end else begin
      state_q   <= state_d;
      // done flags only live while we stay in LWR
      aw_done_q <= (state_d == ST_LWR) && (aw_done_q | (axi.awvalid & axi.awready));
      w_done_q  <= (state_d == ST_LWR) && (w_done_q | (axi.wvalid & axi.wready));

      case (state_q)
        ST_IDLE:  data_q <= '0;
        ST_LRD_D: if (axi.rvalid) data_q <= axi.rdata;
        ST_SMR:   if (axi.sm_tvalid) data_q <= axi.sm_tdata;
        default:  ;
      endcase

      if (state_q == ST_LWR && lite_done) begin
        if (axi.awaddr == ADDR_W'(OFF_LEN)) len_q <= axi.wdata;
        if (axi.awaddr == ADDR_W'(OFF_CTRL) && axi.wdata[0]) x_cnt <= '0;
      end else if (axi.ss_tvalid && axi.ss_tready && len_q != '0 &&
                   x_cnt < len_q - DATA_W'(1)) begin
        x_cnt <= x_cnt + DATA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_axi_fir_bridge.sv
// Self-checking bench for wb_axi_fir_bridge: table of Wishbone accesses with
// behavioural AXI/stream responders and an expected-read-data queue.
module tb_wb_axi_fir_bridge;
  import fir_bridge_pkg::*;

  localparam int K_NONE = 0, K_LW = 1, K_LR = 2, K_X = 3, K_Y = 4;

  typedef struct {
    int          kind;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] resp;
    int          d0;
    int          d1;
    logic [31:0] exp_rd;
    int          exp_lat;
    bit          exp_tlast;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_wb_if wb ();
  fir_axi_if #(.DATA_W(32), .ADDR_W(12)) axi ();

  wb_axi_fir_bridge #(.BASE_ADDR(32'h3000_0000), .DATA_W(32), .ADDR_W(12)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (wb.slave),
    .axi      (axi.slave)
  );

  int checks = 0;
  int failures = 0;

  // responder knobs: d0 for AW/AR/ss/sm, d1 for W/R
  int          d0 = 0, d1 = 0;
  logic [31:0] cur_resp = '0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, ss_wait = 0, sm_wait = 0;

  int          n_aw = 0, n_w = 0, n_ar = 0, n_r = 0, n_ss = 0, n_sm = 0;
  logic [11:0] last_awaddr, last_araddr;
  logic [31:0] last_wdata, last_ss;
  logic        last_tlast;

  logic [31:0] exp_q[$];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.rvalid = 0;
    axi.ss_tready = 0; axi.sm_tvalid = 0;
  end

  always @(negedge clk) begin
    axi.rdata    = cur_resp;
    axi.sm_tdata = cur_resp;
    if (axi.awvalid) begin if (aw_wait >= d0) axi.awready = 1; else begin axi.awready = 0; aw_wait++; end end
    else begin axi.awready = 0; aw_wait = 0; end
    if (axi.wvalid) begin if (w_wait >= d1) axi.wready = 1; else begin axi.wready = 0; w_wait++; end end
    else begin axi.wready = 0; w_wait = 0; end
    if (axi.arvalid) begin if (ar_wait >= d0) axi.arready = 1; else begin axi.arready = 0; ar_wait++; end end
    else begin axi.arready = 0; ar_wait = 0; end
    if (axi.rready) begin if (r_wait >= d1) axi.rvalid = 1; else begin axi.rvalid = 0; r_wait++; end end
    else begin axi.rvalid = 0; r_wait = 0; end
    if (axi.ss_tvalid) begin if (ss_wait >= d0) axi.ss_tready = 1; else begin axi.ss_tready = 0; ss_wait++; end end
    else begin axi.ss_tready = 0; ss_wait = 0; end
    if (axi.sm_tready) begin if (sm_wait >= d0) axi.sm_tvalid = 1; else begin axi.sm_tvalid = 0; sm_wait++; end end
    else begin axi.sm_tvalid = 0; sm_wait = 0; end
  end

  always @(posedge clk) begin
    if (axi.awvalid && axi.awready) begin n_aw++; last_awaddr = axi.awaddr; end
    if (axi.wvalid && axi.wready) begin n_w++; last_wdata = axi.wdata; end
    if (axi.arvalid && axi.arready) begin n_ar++; last_araddr = axi.araddr; end
    if (axi.rvalid && axi.rready) n_r++;
    if (axi.ss_tvalid && axi.ss_tready) begin n_ss++; last_ss = axi.ss_tdata; last_tlast = axi.ss_tlast; end
    if (axi.sm_tvalid && axi.sm_tready) n_sm++;
  end

  // Called #1 after a rising edge; lat = rising edges from strobe to the ack being visible.
  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input int budget, output logic [31:0] rd, output int lat);
    lat = -1;
    rd  = '0;
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr; wb.wbs_dat_i = dat; wb.wbs_sel_i = 4'hF;
    for (int i = 1; i <= budget && lat < 0; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) begin rd = wb.wbs_dat_o; lat = i; end
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    if (lat >= 0) begin
      @(posedge clk); #1;
      check("ack_single_cycle", {31'b0, wb.wbs_ack_o}, 32'd0);
    end
  endtask

  function automatic vec_t mk(int kind, bit we, logic [31:0] adr, logic [31:0] dat,
                              logic [31:0] resp, int a, int b, logic [31:0] exp_rd,
                              int exp_lat, bit exp_tlast);
    vec_t v;
    v.kind = kind; v.we = we; v.adr = adr; v.dat = dat; v.resp = resp;
    v.d0 = a; v.d1 = b; v.exp_rd = exp_rd; v.exp_lat = exp_lat; v.exp_tlast = exp_tlast;
    return v;
  endfunction

  function automatic logic [23:0] hs_exp(int kind);
    case (kind)
      K_LW:    return 24'h110000;
      K_LR:    return 24'h001100;
      K_X:     return 24'h000010;
      K_Y:     return 24'h000001;
      default: return 24'h000000;
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    int          lat;
    int          s_aw, s_w, s_ar, s_r, s_ss, s_sm;
    logic [23:0] hs_act;
    bit          saw_ack;

    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;

    //            kind    we  adr            dat           resp          d0  d1 exp_rd        lat tlast
    vecs.push_back(mk(K_LW,  1, 32'h3000_0040, 32'h0000_0005, 32'h0,        0,  2, 32'h0,          4, 0));
    vecs.push_back(mk(K_LR,  0, 32'h3000_0000, 32'h0,         32'h4,        1,  3, 32'h4,          7, 0));
    vecs.push_back(mk(K_LW,  1, 32'h3000_0010, 32'h3,         32'h0,        0,  0, 32'h0,          2, 0));
    vecs.push_back(mk(K_LW,  1, 32'h3000_0000, 32'h1,         32'h0,        0,  0, 32'h0,          2, 0));
    vecs.push_back(mk(K_X,   1, 32'h3000_0080, 32'h11,        32'h0,        0,  0, 32'h0,          2, 0));
    vecs.push_back(mk(K_X,   1, 32'h3000_0080, 32'h12,        32'h0,        0,  0, 32'h0,          2, 0));
    vecs.push_back(mk(K_X,   1, 32'h3000_0080, 32'h13,        32'h0,        0,  0, 32'h0,          2, 1));
    vecs.push_back(mk(K_X,   1, 32'h3000_0080, 32'h14,        32'h0,        0,  0, 32'h0,          2, 1));
    vecs.push_back(mk(K_Y,   0, 32'h3000_0084, 32'h0,         32'hFFFF_FFF6, 50, 0, 32'hFFFF_FFF6, 52, 0));
    vecs.push_back(mk(K_NONE,0, 32'h3000_0088, 32'h0,         32'hDEAD_BEEF, 0, 0, 32'h0,          1, 0));
    vecs.push_back(mk(K_NONE,1, 32'h3000_0084, 32'h99,        32'hDEAD_BEEF, 0, 0, 32'h0,          1, 0));
    vecs.push_back(mk(K_NONE,0, 32'h3000_0080, 32'h0,         32'hDEAD_BEEF, 0, 0, 32'h0,          1, 0));
    vecs.push_back(mk(K_NONE,1, 32'h3000_00FC, 32'h7,         32'h0,        0,  0, 32'h0,          1, 0));
    vecs.push_back(mk(K_NONE,0, 32'h2000_0000, 32'h0,         32'h0,        0,  0, 32'h0,         -1, 0));
    vecs.push_back(mk(K_LW,  1, 32'h3000_0040, 32'h1234,      32'h0,        3,  0, 32'h0,          5, 0));
    vecs.push_back(mk(K_LW,  1, 32'h3000_0044, 32'hABCD,      32'h0,        1,  1, 32'h0,          3, 0));
    vecs.push_back(mk(K_X,   1, 32'h3000_0080, 32'h15,        32'h0,        0,  0, 32'h0,          2, 1));
    vecs.push_back(mk(K_LW,  1, 32'h3000_0000, 32'h0,         32'h0,        0,  0, 32'h0,          2, 0));
    vecs.push_back(mk(K_X,   1, 32'h3000_0080, 32'h16,        32'h0,        0,  0, 32'h0,          2, 1));
    vecs.push_back(mk(K_LW,  1, 32'h3000_0000, 32'h1,         32'h0,        0,  0, 32'h0,          2, 0));
    vecs.push_back(mk(K_X,   1, 32'h3000_0080, 32'h17,        32'h0,        0,  0, 32'h0,          2, 0));
    vecs.push_back(mk(K_Y,   0, 32'h3000_0084, 32'h0,         32'h0000_0005, 0, 0, 32'h5,          2, 0));
    vecs.push_back(mk(K_LR,  0, 32'h3000_007C, 32'h0,         32'h77,       0,  0, 32'h77,         3, 0));

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   {31'b0, wb.wbs_ack_o}, 32'd0);
    check("rst_dat",   wb.wbs_dat_o, 32'd0);
    check("rst_valids", {26'b0, axi.awvalid, axi.wvalid, axi.arvalid, axi.rready,
                         axi.ss_tvalid, axi.sm_tready}, 32'd0);
    check("rst_tlast", {31'b0, axi.ss_tlast}, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      d0 = vecs[i].d0; d1 = vecs[i].d1; cur_resp = vecs[i].resp;
      s_aw = n_aw; s_w = n_w; s_ar = n_ar; s_r = n_r; s_ss = n_ss; s_sm = n_sm;
      if (vecs[i].exp_lat >= 0) exp_q.push_back(vecs[i].exp_rd);
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat,
              (vecs[i].exp_lat >= 0) ? vecs[i].exp_lat + 20 : 10, rd, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      if (lat >= 0 && exp_q.size() > 0) check($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
      else if (vecs[i].exp_lat >= 0) void'(exp_q.pop_front());
      hs_act = {4'(n_aw - s_aw), 4'(n_w - s_w), 4'(n_ar - s_ar), 4'(n_r - s_r),
                4'(n_ss - s_ss), 4'(n_sm - s_sm)};
      check($sformatf("v%0d_handshakes", i), {8'b0, hs_act}, {8'b0, hs_exp(vecs[i].kind)});
      case (vecs[i].kind)
        K_LW: begin
          check($sformatf("v%0d_awaddr", i), {20'b0, last_awaddr}, {20'b0, vecs[i].adr[11:0]});
          check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].dat);
        end
        K_LR: check($sformatf("v%0d_araddr", i), {20'b0, last_araddr}, {20'b0, vecs[i].adr[11:0]});
        K_X: begin
          check($sformatf("v%0d_tdata", i), last_ss, vecs[i].dat);
          check($sformatf("v%0d_tlast", i), {31'b0, last_tlast}, {31'b0, vecs[i].exp_tlast});
        end
        default: ;
      endcase
      d0 = 0; d1 = 0;
      @(posedge clk); #1;
    end

    // reset while an X push is stalled on ss_tready
    d0 = 1000;
    s_ss = n_ss;
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 1;
    wb.wbs_adr_i = 32'h3000_0080; wb.wbs_dat_i = 32'hAA;
    repeat (3) @(posedge clk);
    #1;
    check("ssw_stalled_tvalid", {31'b0, axi.ss_tvalid}, 32'd1);
    rst = 1;
    @(posedge clk); #1;
    check("rst_mid_tvalid", {31'b0, axi.ss_tvalid}, 32'd0);
    check("rst_mid_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    rst = 0;
    d0 = 0;
    saw_ack = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) saw_ack = 1;
    end
    check("rst_mid_no_ack", {31'b0, saw_ack}, 32'd0);
    check("rst_mid_no_hs", n_ss - s_ss, 32'd0);

    // the next access completes normally, and len_q was cleared by reset
    exp_q.push_back(32'h0);
    wb_xfer(1'b1, 32'h3000_0080, 32'h5A, 20, rd, lat);
    check("post_rst_latency", lat, 32'd2);
    check("post_rst_rdata", rd, exp_q.pop_front());
    check("post_rst_tdata", last_ss, 32'h5A);
    check("post_rst_tlast", {31'b0, last_tlast}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
